gpio_in_cond: RTL and testbench
===============================

Name: gpio_in_cond

Overview:
Input-direction conditioning for the 16-pin GPIO port. Takes the raw asynchronous pad inputs (gpio_in from the pad ring) and produces clean data for the GPIO register file. Processing per pin: 2-flop synchroniser, optional prescaled glitch filter, configurable edge detection, and sticky interrupt-pending bits with a combined IRQ. Sits between the pad ring and the GPIO AHB register slice.

Parameters:
WIDTH, 16, number of GPIO pins
CNT_W, 4, filter-length counter width
PRE_W, 8, filter prescaler width

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
gpio_in  input  WIDTH  raw pad inputs, asynchronous to clk
r_filt_en  input  WIDTH  per-pin filter enable; 0 = bypass
r_filt_pre  input  PRE_W  filter tick prescaler; tick every r_filt_pre+1 cycles
r_filt_len  input  CNT_W  filter length; new level accepted after r_filt_len+1 consecutive differing ticks
r_trig_rise  input  WIDTH  per-pin rising-edge detect enable
r_trig_fall  input  WIDTH  per-pin falling-edge detect enable
r_int_en  input  WIDTH  per-pin interrupt enable
int_clr  input  WIDTH  write-1-to-clear pulse for int_pend
gpio_idr  output  WIDTH  conditioned input data
edge_pulse  output  WIDTH  one-cycle pulse per qualified edge
int_pend  output  WIDTH  sticky interrupt-pending flags
irq  output  1  OR of int_pend

Behaviour:
- Clock is clk; reset is synchronous and active-low on rst_n. All registers reset on the clk edge where rst_n=0.
- Reset values: sync stages 0, gpio_idr 0, edge_pulse 0, int_pend 0, irq 0, prescaler 0, filter counters 0, startup counter 0.
- Synchroniser: 2 flops per pin. sync = second stage.
- Startup:
  - 2-bit startup counter runs after reset release.
  - While counter < 2, gpio_idr is loaded directly from sync every cycle and edge_pulse is forced 0.
  - From counter = 2 onward, normal operation. This means a pad at reset level 1 produces no spurious edge.
- Prescaler:
  - Free-running counter 0..r_filt_pre. tick = (count == r_filt_pre); count wraps to 0 on tick.
  - r_filt_pre = 0 gives tick every cycle.
  - If r_filt_pre is lowered below the current count, the counter wraps to 0 on the next cycle with no tick.
- Filter, per pin, when r_filt_en=0:
  - gpio_idr <= sync each cycle; counter held at 0.
  - Latency from pad change to gpio_idr is 3 clk.
- Filter, per pin, when r_filt_en=1:
  - sync == gpio_idr: counter <= 0.
  - sync != gpio_idr and tick with counter >= r_filt_len: gpio_idr <= sync, counter <= 0.
  - sync != gpio_idr and tick otherwise: counter++.
  - A glitch that returns before acceptance clears the counter; no output change.
  - Toggling r_filt_en clears the counter on the same cycle. The >= compare tolerates r_filt_len being lowered mid-count.
- Edge detect:
  - edge_pulse[i] = (gpio_idr rises & r_trig_rise[i]) | (gpio_idr falls & r_trig_fall[i]).
  - Registered, asserted the cycle after gpio_idr changes, for exactly 1 cycle.
  - Both trig bits set means both edges are detected.
- Interrupt pending:
  - int_pend[i] <= (int_pend[i] & ~int_clr[i]) | (edge_pulse[i] & r_int_en[i]).
  - When set and clear coincide, set wins; no event is lost.
  - Clearing r_int_en does not clear an already pending bit.
- irq = |int_pend, combinational from the int_pend flops, so it is glitch-free.
- Reset mid-filter or mid-pend: all state is discarded and startup is re-run.

Decomposition:
- Shared gpio package holds WIDTH, CNT_W, PRE_W defaults and the startup count constant (2). The same constants are reused by the GPIO register slice.
- One natural sub-module: gpio_in_filter_slice. It covers one pin: sync flops, filter counter, gpio_idr bit, edge and pend logic. Instantiate it WIDTH times with a generate loop.
- The prescaler and startup counter live in the top of gpio_in_cond and are shared by all slices.

Test Plan:
1. Bypass: r_filt_en=0, pin0 0->1 at cycle 10 -> gpio_idr[0]=1 at cycle 13; with r_trig_rise[0]=1, edge_pulse[0]=1 at cycle 14 only.
2. Filter accept: r_filt_en[1]=1, pre=3, len=2, pin1 held high -> gpio_idr[1] rises after 3 ticks (12 cycles, ±4 for prescaler phase).
3. Glitch reject: same config, pin1 high for 6 cycles, then low -> gpio_idr[1] stays 0, edge_pulse[1] never asserts.
4. Interrupt: r_int_en[2]=1, r_trig_fall[2]=1, pin2 1->0 -> int_pend[2]=1 and irq=1; int_clr[2] pulse -> both 0 next cycle. Clear coinciding with a new edge -> int_pend[2] stays 1.
5. Startup: all pads held 1 through reset -> gpio_idr=16'hFFFF within 3 cycles of reset release, edge_pulse and int_pend remain 0.
6. Reset mid-count: filter counter at 1, assert rst_n=0 for 1 cycle -> all outputs 0; release -> startup sequence repeats.

Source files
------------

// File: rtl/gpio_in_cond_pkg.sv
// Shared GPIO constants: port width, filter counter widths and the startup length.
package gpio_in_cond_pkg;

  localparam int unsigned GPIO_WIDTH       = 16;
  localparam int unsigned GPIO_CNT_W       = 4;
  localparam int unsigned GPIO_PRE_W       = 8;
  localparam int unsigned GPIO_STARTUP_W   = 2;
  localparam int unsigned GPIO_STARTUP_CNT = 2;

endpackage

// File: rtl/gpio_in_filter_slice.sv
// One GPIO input pin: synchroniser, glitch filter, edge detect and sticky pending bit.
module gpio_in_filter_slice
  import gpio_in_cond_pkg::*;
#(
  parameter int unsigned CNT_W = GPIO_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pad,
  input  logic             startup,
  input  logic             tick,
  input  logic             filt_en,
  input  logic [CNT_W-1:0] filt_len,
  input  logic             trig_rise,
  input  logic             trig_fall,
  input  logic             int_en,
  input  logic             int_clr,
  output logic             idr,
  output logic             edge_pulse,
  output logic             int_pend
);

  logic             s1;
  logic             s2;
  logic             idr_d;
  logic             idr_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             rise;
  logic             fall;

  // Filter next state; during startup idr is preloaded from the stage feeding
  // sync so it has already settled when normal operation begins.
  always_comb begin
    idr_nxt = idr;
    cnt_nxt = '0;
    if (startup) begin
      idr_nxt = s1;
    end else if (!filt_en) begin
      idr_nxt = s2;
    end else if (s2 != idr) begin
      if (tick) begin
        if (cnt >= filt_len) idr_nxt = s2;
        else                 cnt_nxt = cnt + CNT_W'(1);
      end else begin
        cnt_nxt = cnt;
      end
    end
  end

  assign rise = idr & ~idr_d;
  assign fall = ~idr & idr_d;

  // Registered pipeline; the edge history tracks idr's preload while in startup.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      idr        <= 1'b0;
      idr_d      <= 1'b0;
      cnt        <= '0;
      edge_pulse <= 1'b0;
      int_pend   <= 1'b0;
    end else begin
      s1         <= pad;
      s2         <= s1;
      idr        <= idr_nxt;
      cnt        <= cnt_nxt;
      idr_d      <= startup ? s1 : idr;
      edge_pulse <= ~startup & ((rise & trig_rise) | (fall & trig_fall));
      int_pend   <= (int_pend & ~int_clr) | (edge_pulse & int_en);
    end
  end

endmodule

// File: rtl/gpio_in_cond.sv
// GPIO input conditioning: shared prescaler and startup counter feeding one filter slice per pin.
module gpio_in_cond
  import gpio_in_cond_pkg::*;
#(
  parameter int unsigned WIDTH = GPIO_WIDTH,
  parameter int unsigned CNT_W = GPIO_CNT_W,
  parameter int unsigned PRE_W = GPIO_PRE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] gpio_in,
  input  logic [WIDTH-1:0] r_filt_en,
  input  logic [PRE_W-1:0] r_filt_pre,
  input  logic [CNT_W-1:0] r_filt_len,
  input  logic [WIDTH-1:0] r_trig_rise,
  input  logic [WIDTH-1:0] r_trig_fall,
  input  logic [WIDTH-1:0] r_int_en,
  input  logic [WIDTH-1:0] int_clr,
  output logic [WIDTH-1:0] gpio_idr,
  output logic [WIDTH-1:0] edge_pulse,
  output logic [WIDTH-1:0] int_pend,
  output logic             irq
);

  logic [GPIO_STARTUP_W-1:0] start_cnt;
  logic                      startup;
  logic [PRE_W-1:0]          pre_cnt;
  logic                      tick;

  assign startup = (start_cnt < GPIO_STARTUP_W'(GPIO_STARTUP_CNT));
  assign tick    = (pre_cnt == r_filt_pre);

  // Startup counter saturates once the synchronisers hold post-reset samples.
  always_ff @(posedge clk) begin
    if (!rst_n)       start_cnt <= '0;
    else if (startup) start_cnt <= start_cnt + GPIO_STARTUP_W'(1);
  end

  // Prescaler wraps silently if the limit is lowered below the current count.
  always_ff @(posedge clk) begin
    if (!rst_n)                              pre_cnt <= '0;
    else if (tick || (pre_cnt > r_filt_pre)) pre_cnt <= '0;
    else                                     pre_cnt <= pre_cnt + PRE_W'(1);
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    gpio_in_filter_slice #(.CNT_W(CNT_W)) u_slice (
      .clk        (clk),
      .rst_n      (rst_n),
      .pad        (gpio_in[i]),
      .startup    (startup),
      .tick       (tick),
      .filt_en    (r_filt_en[i]),
      .filt_len   (r_filt_len),
      .trig_rise  (r_trig_rise[i]),
      .trig_fall  (r_trig_fall[i]),
      .int_en     (r_int_en[i]),
      .int_clr    (int_clr[i]),
      .idr        (gpio_idr[i]),
      .edge_pulse (edge_pulse[i]),
      .int_pend   (int_pend[i])
    );
  end

  assign irq = |int_pend;

endmodule

// File: tb/tb_gpio_in_cond.sv
// Scoreboard bench for gpio_in_cond: timed expectations queued with stimulus, checked at negedge.
module tb_gpio_in_cond;
  import gpio_in_cond_pkg::*;

  localparam int unsigned W = GPIO_WIDTH;

  logic                  clk;
  logic                  rst_n;
  logic [W-1:0]          gpio_in;
  logic [W-1:0]          r_filt_en;
  logic [GPIO_PRE_W-1:0] r_filt_pre;
  logic [GPIO_CNT_W-1:0] r_filt_len;
  logic [W-1:0]          r_trig_rise;
  logic [W-1:0]          r_trig_fall;
  logic [W-1:0]          r_int_en;
  logic [W-1:0]          int_clr;
  logic [W-1:0]          gpio_idr;
  logic [W-1:0]          edge_pulse;
  logic [W-1:0]          int_pend;
  logic                  irq;

  gpio_in_cond dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .gpio_in     (gpio_in),
    .r_filt_en   (r_filt_en),
    .r_filt_pre  (r_filt_pre),
    .r_filt_len  (r_filt_len),
    .r_trig_rise (r_trig_rise),
    .r_trig_fall (r_trig_fall),
    .r_int_en    (r_int_en),
    .int_clr     (int_clr),
    .gpio_idr    (gpio_idr),
    .edge_pulse  (edge_pulse),
    .int_pend    (int_pend),
    .irq         (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int SEL_IDR = 0, SEL_EDGE = 1, SEL_PEND = 2, SEL_IRQ = 3;

  typedef struct {
    int unsigned  at;
    string        tag;
    int           sel;
    logic [W-1:0] mask;
    logic [W-1:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] obs_sel(input int sel);
    case (sel)
      SEL_IDR:  return gpio_idr;
      SEL_EDGE: return edge_pulse;
      SEL_PEND: return int_pend;
      default:  return {{(W-1){1'b0}}, irq};
    endcase
  endfunction

  task automatic expect_at(input int unsigned at, input string tag, input int sel,
                           input logic [W-1:0] mask, input logic [W-1:0] exp);
    exp_t e;
    e.at = at; e.tag = tag; e.sel = sel; e.mask = mask; e.exp = exp;
    sb.push_back(e);
  endtask

  // Retire every expectation whose cycle has arrived; anything overdue is a miss.
  always @(negedge clk) begin : monitor
    exp_t keep[$];
    keep = {};
    foreach (sb[i]) begin
      if (sb[i].at == cyc)
        check(sb[i].tag, 32'(obs_sel(sb[i].sel) & sb[i].mask), 32'(sb[i].exp & sb[i].mask));
      else if (sb[i].at < cyc)
        check({sb[i].tag, "_missed"}, 32'd0, 32'd1);
      else
        keep.push_back(sb[i]);
    end
    sb = keep;
  end

  task automatic go(input int unsigned c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int unsigned r, t, c, p, q, f, g;
    int          lat;
    logic        found;

    rst_n       = 1'b0;
    gpio_in     = '1;
    r_filt_en   = '0;
    r_filt_pre  = '0;
    r_filt_len  = '0;
    r_trig_rise = '1;
    r_trig_fall = '1;
    r_int_en    = '1;
    int_clr     = '0;

    // Reset state, pads high during reset
    go(3);
    @(negedge clk);
    check("rst_idr",  32'(gpio_idr),   32'd0);
    check("rst_edge", 32'(edge_pulse), 32'd0);
    check("rst_pend", 32'(int_pend),   32'd0);
    check("rst_irq",  32'(irq),        32'd0);

    // Startup with all pads at 1: settle without spurious edges
    go(5);
    rst_n = 1'b1;
    r = cyc;
    expect_at(r + 3, "start_idr", SEL_IDR, '1, '1);
    for (int k = 1; k <= 8; k++) expect_at(r + k, "start_edge", SEL_EDGE, '1, '0);
    expect_at(r + 8, "start_pend", SEL_PEND, '1, '0);
    expect_at(r + 8, "start_irq",  SEL_IRQ,  '1, '0);
    go(r + 10);

    // Working configuration
    rst_n       = 1'b0;
    gpio_in     = '0;
    r_filt_en   = 16'h0002;
    r_filt_pre  = 8'd3;
    r_filt_len  = 4'd2;
    r_trig_rise = 16'h0003;
    r_trig_fall = 16'h0006;
    r_int_en    = 16'h0004;
    go(cyc + 2);
    rst_n = 1'b1;
    go(cyc + 10);

    // Bypass latency and single-cycle edge
    t = cyc;
    gpio_in[0] = 1'b1;
    expect_at(t + 2, "byp_idr_early", SEL_IDR,  16'h0001, 16'h0000);
    expect_at(t + 3, "byp_idr",       SEL_IDR,  16'h0001, 16'h0001);
    expect_at(t + 3, "byp_edge_pre",  SEL_EDGE, 16'h0001, 16'h0000);
    expect_at(t + 4, "byp_edge",      SEL_EDGE, 16'h0001, 16'h0001);
    expect_at(t + 5, "byp_edge_post", SEL_EDGE, 16'h0001, 16'h0000);
    go(t + 8);

    // Glitch shorter than the filter window is rejected
    t = cyc;
    for (int k = 1; k <= 20; k++) begin
      expect_at(t + k, "glitch_idr",  SEL_IDR,  16'h0002, 16'h0000);
      expect_at(t + k, "glitch_edge", SEL_EDGE, 16'h0002, 16'h0000);
    end
    gpio_in[1] = 1'b1;
    go(t + 6);
    gpio_in[1] = 1'b0;
    go(t + 22);

    // Filtered level accepted after three ticks
    t = cyc;
    gpio_in[1] = 1'b1;
    found = 1'b0;
    lat = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (gpio_idr[1]) begin
        found = 1'b1;
        lat = int'(cyc - t);
        break;
      end
    end
    check("filt_found", 32'(found), 32'd1);
    check("filt_lat_in_window", 32'((lat >= 8) && (lat <= 16)), 32'd1);
    if (found) begin
      c = cyc;
      expect_at(c + 1, "filt_edge",      SEL_EDGE, 16'h0002, 16'h0002);
      expect_at(c + 2, "filt_edge_post", SEL_EDGE, 16'h0002, 16'h0000);
      expect_at(c + 3, "filt_no_pend",   SEL_PEND, 16'h0002, 16'h0000);
    end
    go(cyc + 6);

    // Pin2 rise is not a qualified edge
    p = cyc;
    gpio_in[2] = 1'b1;
    expect_at(p + 4, "int_rise_edge",  SEL_EDGE, 16'h0004, 16'h0000);
    expect_at(p + 5, "int_rise_edge2", SEL_EDGE, 16'h0004, 16'h0000);
    expect_at(p + 6, "int_rise_pend",  SEL_PEND, 16'h0004, 16'h0000);
    go(p + 8);

    // Falling edge sets pending; clear pulse removes it
    q = cyc;
    gpio_in[2] = 1'b0;
    expect_at(q + 3, "int_idr",       SEL_IDR,  16'h0004, 16'h0000);
    expect_at(q + 4, "int_edge",      SEL_EDGE, 16'h0004, 16'h0004);
    expect_at(q + 5, "int_pend",      SEL_PEND, 16'h0004, 16'h0004);
    expect_at(q + 5, "int_irq",       SEL_IRQ,  '1,       16'h0001);
    expect_at(q + 7, "int_sticky",    SEL_PEND, 16'h0004, 16'h0004);
    expect_at(q + 8, "int_clr_pend",  SEL_PEND, 16'h0004, 16'h0000);
    expect_at(q + 8, "int_clr_irq",   SEL_IRQ,  '1,       16'h0000);
    go(q + 7);
    int_clr = 16'h0004;
    go(q + 8);
    int_clr = '0;

    // Clear coinciding with a new edge: set wins; disabling int_en keeps pend
    go(q + 10);
    gpio_in[2] = 1'b1;
    go(q + 18);
    f = cyc;
    gpio_in[2] = 1'b0;
    expect_at(f + 4, "coin_edge",   SEL_EDGE, 16'h0004, 16'h0004);
    expect_at(f + 5, "coin_pend",   SEL_PEND, 16'h0004, 16'h0004);
    expect_at(f + 6, "coin_pend2",  SEL_PEND, 16'h0004, 16'h0004);
    expect_at(f + 6, "coin_irq",    SEL_IRQ,  '1,       16'h0001);
    expect_at(f + 9, "pend_kept",   SEL_PEND, 16'h0004, 16'h0004);
    go(f + 4);
    int_clr = 16'h0004;
    go(f + 5);
    int_clr = '0;
    go(f + 6);
    r_int_en = '0;
    go(f + 10);

    // Reset while pin1's filter counter is mid-count
    g = cyc;
    gpio_in[1] = 1'b0;
    go(g + 6);
    rst_n = 1'b0;
    expect_at(g + 7, "mid_rst_idr",  SEL_IDR,  '1, '0);
    expect_at(g + 7, "mid_rst_edge", SEL_EDGE, '1, '0);
    expect_at(g + 7, "mid_rst_pend", SEL_PEND, '1, '0);
    expect_at(g + 7, "mid_rst_irq",  SEL_IRQ,  '1, '0);
    go(g + 7);
    rst_n = 1'b1;
    expect_at(g + 10, "restart_idr", SEL_IDR, '1, 16'h0001);
    for (int k = 8; k <= 13; k++) expect_at(g + k, "restart_edge", SEL_EDGE, '1, '0);
    expect_at(g + 13, "restart_pend", SEL_PEND, '1, '0);

    go(cyc + 20);
    check("sb_drain", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
